// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: control-unit request, PC feedback and instruction-memory read handshake.
// master = fetch unit, slave = control unit / PC register / instruction memory side.
interface instr_fetch_unit_if #(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_WIDTH  = 8
);
  logic                   fetch_start;
  logic [WORD_LENGTH-1:0] pc_in;
  logic                   fault_clear;
  logic [WORD_LENGTH-1:0] mem_rdata;
  logic                   mem_ready;
  logic                   mem_req;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [WORD_LENGTH-1:0] instr_out;
  logic                   instr_valid;
  logic [WORD_LENGTH-1:0] pc_next;
  logic                   pc_write;
  logic                   busy;
  logic                   fault;

  modport master (
    input  fetch_start, pc_in, fault_clear, mem_rdata, mem_ready,
    output mem_req, mem_addr, instr_out, instr_valid, pc_next, pc_write, busy, fault
  );

  modport slave (
    output fetch_start, pc_in, fault_clear, mem_rdata, mem_ready,
    input  mem_req, mem_addr, instr_out, instr_valid, pc_next, pc_write, busy, fault
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC -> word address, req/ready read, instruction register, PC+4 write-back.
// Optional macro FETCH_TIMEOUT_EN adds a REQ watchdog that faults after TIMEOUT_CYCLES.
//
// state   | meaning
// IDLE    | waiting for fetch_start, PC range/alignment checked on capture
// REQ     | mem_req held with stable mem_addr until mem_ready
// DONE    | one cycle: instr_valid and pc_write pulse
// FAULT   | sticky misaligned/out-of-segment/timeout fault, left via fault_clear
module instr_fetch_unit #(
  parameter int                     WORD_LENGTH     = 32,
  parameter logic [WORD_LENGTH-1:0] TEXT_BASE       = 32'h0040_0000,
  parameter int                     MEM_DEPTH_WORDS = 256,
  parameter int                     ADDR_WIDTH      = 8,
  parameter int                     TIMEOUT_CYCLES  = 16
) (
  input  logic              clk,
  input  logic              reset,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  // One extra bit so the end of the text segment cannot wrap.
  localparam logic [WORD_LENGTH:0] TEXT_END =
    {1'b0, TEXT_BASE} + (WORD_LENGTH+1)'(4 * MEM_DEPTH_WORDS);

  state_t                 state_q, state_d;
  logic [WORD_LENGTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [WORD_LENGTH-1:0] instr_q, instr_d;
  logic [WORD_LENGTH-1:0] pc_next_q, pc_next_d;
  logic                   addr_bad;
  logic                   tmo_hit;

  assign addr_bad = (bus.pc_in[1:0] != 2'b00) ||
                    (bus.pc_in < TEXT_BASE) ||
                    ({1'b0, bus.pc_in} >= TEXT_END);

`ifdef FETCH_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q != S_REQ) begin
      tmo_cnt_d = '0;
    end else if (!bus.mem_ready) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  // Fires on the REQ cycle whose miss would bring the count to TIMEOUT_CYCLES.
  assign tmo_hit = (state_q == S_REQ) && !bus.mem_ready &&
                   (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  // Without the watchdog the timeout length has no hardware to size.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.fetch_start) begin
          state_d = addr_bad ? S_FAULT : S_REQ;
        end
      end
      S_REQ: begin
        if (bus.mem_ready) begin
          state_d = S_DONE;
        end else if (tmo_hit) begin
          state_d = S_FAULT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: begin
        if (bus.fault_clear) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    addr_d    = addr_q;
    instr_d   = instr_q;
    pc_next_d = pc_next_q;
    if ((state_q == S_IDLE) && bus.fetch_start) begin
      pc_d = bus.pc_in;
      if (!addr_bad) begin
        addr_d = ADDR_WIDTH'((bus.pc_in - TEXT_BASE) >> 2);
      end
    end
    if ((state_q == S_REQ) && bus.mem_ready) begin
      instr_d   = bus.mem_rdata;
      pc_next_d = pc_q + WORD_LENGTH'(4);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= '0;
      addr_q    <= '0;
      instr_q   <= '0;
      pc_next_q <= '0;
    end else begin
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      instr_q   <= instr_d;
      pc_next_q <= pc_next_d;
    end
  end

  always_comb begin
    bus.mem_req     = (state_q == S_REQ);
    bus.mem_addr    = addr_q;
    bus.instr_out   = instr_q;
    bus.pc_next     = pc_next_q;
    bus.instr_valid = (state_q == S_DONE);
    bus.pc_write    = (state_q == S_DONE);
    bus.busy        = (state_q == S_REQ) || (state_q == S_DONE);
    bus.fault       = (state_q == S_FAULT);
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized self-checking bench for instr_fetch_unit against a transaction-level fetch model.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
  localparam int          WL    = 32;
  localparam int          AW    = 8;
  localparam int          DEPTH = 256;
  localparam int          TMO   = 16;
  localparam logic [31:0] BASE  = 32'h0040_0000;
`ifdef FETCH_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  logic [31:0] exp_instr;
  logic [31:0] exp_pcn;

  instr_fetch_unit_if #(.WORD_LENGTH(WL), .ADDR_WIDTH(AW)) bus ();

  instr_fetch_unit #(
    .WORD_LENGTH(WL), .TEXT_BASE(BASE), .MEM_DEPTH_WORDS(DEPTH),
    .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit pc_bad(input logic [31:0] pc);
    longint p;
    p = longint'(pc);
    return (p % 4 != 0) || (p < longint'(BASE)) || (p >= longint'(BASE) + 4 * DEPTH);
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_req"},   32'(bus.mem_req), 0);
    chk({tag, "_busy"},  32'(bus.busy), 0);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 0);
    chk({tag, "_pcw"},   32'(bus.pc_write), 0);
    chk({tag, "_fault"}, 32'(bus.fault), 0);
    chk({tag, "_instr"}, bus.instr_out, exp_instr);
    chk({tag, "_pcn"},   bus.pc_next, exp_pcn);
  endtask

  // Called at a negedge where the fault is expected to be visible.
  task automatic fault_path(input string tag);
    chk({tag, "_fault"}, 32'(bus.fault), 1);
    chk({tag, "_req"},   32'(bus.mem_req), 0);
    chk({tag, "_busy"},  32'(bus.busy), 0);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 0);
    chk({tag, "_pcw"},   32'(bus.pc_write), 0);
    chk({tag, "_instr"}, bus.instr_out, exp_instr);
    chk({tag, "_pcn"},   bus.pc_next, exp_pcn);
    bus.fetch_start = 1'b1;
    bus.pc_in       = BASE;
    bus.mem_ready   = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus.fetch_start = 1'b0;
    bus.mem_ready   = 1'b0;
    chk({tag, "_sticky"},    32'(bus.fault), 1);
    chk({tag, "_sticky_rq"}, 32'(bus.mem_req), 0);
    bus.fault_clear = 1'b1;
    @(negedge clk);
    bus.fault_clear = 1'b0;
    check_idle({tag, "_clr"});
  endtask

  // Entered and left at a negedge with the DUT idle.
  task automatic fetch(input string tag, input logic [31:0] pc, input int wait_n,
                       input logic [31:0] data);
    bit timed_out;
    int n;
    timed_out = TMO_EN && (wait_n >= TMO);
    n = timed_out ? TMO : wait_n + 1;
    bus.fetch_start = 1'b1;
    bus.pc_in       = pc;
    bus.mem_ready   = 1'($urandom_range(0, 1));
    bus.mem_rdata   = $urandom;
    @(negedge clk);
    bus.fetch_start = 1'b0;
    bus.mem_ready   = 1'b0;
    bus.pc_in       = $urandom;
    if (pc_bad(pc)) begin
      fault_path({tag, "_bad"});
      return;
    end
    for (int i = 0; i < n; i++) begin
      chk({tag, "_req"},   32'(bus.mem_req), 1);
      chk({tag, "_addr"},  32'(bus.mem_addr), (pc - BASE) / 4);
      chk({tag, "_busy"},  32'(bus.busy), 1);
      chk({tag, "_valid"}, 32'(bus.instr_valid), 0);
      chk({tag, "_pcw"},   32'(bus.pc_write), 0);
      chk({tag, "_fault"}, 32'(bus.fault), 0);
      bus.fault_clear = 1'($urandom_range(0, 1));
      if (i == wait_n) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = data;
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = $urandom;
      end
      @(negedge clk);
    end
    bus.mem_ready   = 1'b0;
    bus.fault_clear = 1'b0;
    if (timed_out) begin
      fault_path({tag, "_tmo"});
      return;
    end
    exp_instr = data;
    exp_pcn   = pc + 32'd4;
    chk({tag, "_dvalid"}, 32'(bus.instr_valid), 1);
    chk({tag, "_dpcw"},   32'(bus.pc_write), 1);
    chk({tag, "_dinstr"}, bus.instr_out, exp_instr);
    chk({tag, "_dpcn"},   bus.pc_next, exp_pcn);
    chk({tag, "_dreq"},   32'(bus.mem_req), 0);
    chk({tag, "_dbusy"},  32'(bus.busy), 1);
    bus.fetch_start = 1'($urandom_range(0, 1));
    bus.pc_in       = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
    @(negedge clk);
    bus.fetch_start = 1'b0;
    check_idle({tag, "_post"});
  endtask

  task automatic reset_mid_req();
    fetch("pre", BASE + 32'h10, 0, 32'hCAFE_0001);
    bus.fetch_start = 1'b1;
    bus.pc_in       = BASE + 32'h20;
    @(negedge clk);
    bus.fetch_start = 1'b0;
    chk("rst_req_before", 32'(bus.mem_req), 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_req_async", 32'(bus.mem_req), 0);
    chk("rst_instr",     bus.instr_out, 0);
    chk("rst_pcn",       bus.pc_next, 0);
    chk("rst_busy",      32'(bus.busy), 0);
    exp_instr = '0;
    exp_pcn   = '0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("rst_after");
    end
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] pc;
    int          w;
    reset           = 1'b1;
    bus.fetch_start = 1'b0;
    bus.pc_in       = '0;
    bus.fault_clear = 1'b0;
    bus.mem_rdata   = '0;
    bus.mem_ready   = 1'b0;
    exp_instr       = '0;
    exp_pcn         = '0;
    #1;
    check_idle("reset");
    chk("reset_addr", 32'(bus.mem_addr), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_idle("idle");
    end
    bus.mem_ready = 1'b0;

    fetch("zero_wait", 32'h0040_0000, 0, 32'h2008_0005);
    fetch("wait3",     32'h0040_03FC, 3, 32'h1234_5678);
    fetch("misalign",  32'h0040_0002, 0, 32'h0);
    fetch("above",     32'h0040_0400, 0, 32'h0);
    fetch("below",     32'h003F_FFFC, 0, 32'h0);
    fetch("after_flt", 32'h0040_0008, 1, 32'hA5A5_5A5A);
    reset_mid_req();
    if (TMO_EN) begin
      fetch("tmo_never", BASE + 32'h40, TMO, 32'h0);
      fetch("tmo_last",  BASE + 32'h44, TMO - 1, 32'h0BAD_F00D);
    end

    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 9))
        0: pc = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
        1: pc = BASE - 32'(4 * $urandom_range(1, 8));
        2: pc = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 8));
        3: pc = $urandom & 32'hFFFF_FFFC;
        4: pc = BASE + 32'(4 * (DEPTH - 1));
        default: pc = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      endcase
      if (TMO_EN && ($urandom_range(0, 7) == 0)) w = $urandom_range(TMO - 1, TMO + 4);
      else w = $urandom_range(0, 6);
      fetch($sformatf("rnd%0d", t), pc, w, $urandom);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        bus.mem_ready   = 1'($urandom_range(0, 1));
        bus.fault_clear = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_idle("gap");
      end
      bus.mem_ready   = 1'b0;
      bus.fault_clear = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly downstream of the program counter register.
- Takes the current PC value, translates it to an instruction-memory word address, and runs a req/ready read handshake.
- Latches the returned word into an instruction register and produces PC+4 plus a one-cycle PC write-enable pulse that feed back into the PC register.
- Flags misaligned or out-of-segment fetches as a sticky fault.

Parameters:
WORD_LENGTH, 32, data/PC width
TEXT_BASE, 32'h0040_0000, byte address of first instruction word
MEM_DEPTH_WORDS, 256, instruction memory depth in words
ADDR_WIDTH, 8, memory word-address width (log2 of MEM_DEPTH_WORDS)
TIMEOUT_CYCLES, 16, max cycles waiting for mem_ready (only with FETCH_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
fetch_start  input  1  control-unit request to fetch at pc_in
pc_in  input  WORD_LENGTH  current PC register output
fault_clear  input  1  clears sticky fault, returns to IDLE
mem_rdata  input  WORD_LENGTH  instruction memory read data
mem_ready  input  1  memory read data valid this cycle
mem_req  output  1  read request to instruction memory
mem_addr  output  ADDR_WIDTH  word address to instruction memory
instr_out  output  WORD_LENGTH  instruction register
instr_valid  output  1  one-cycle pulse: instr_out newly loaded
pc_next  output  WORD_LENGTH  captured PC + 4
pc_write  output  1  one-cycle enable pulse for the PC register
busy  output  1  high in REQ and DONE
fault  output  1  sticky address/timeout fault

Behaviour:
- Reset (async, high): state IDLE; all outputs 0 (mem_req, mem_addr, instr_out, instr_valid, pc_next, pc_write, busy, fault). Reset mid-handshake drops mem_req immediately.
- States: IDLE, REQ, DONE, FAULT.
- IDLE, fetch_start=1: capture pc_in into pc_q.
  - If pc_in[1:0]!=0, or pc_in < TEXT_BASE, or pc_in >= TEXT_BASE + 4*MEM_DEPTH_WORDS: go to FAULT.
  - Otherwise go to REQ with mem_addr = ((pc_in - TEXT_BASE) >> 2) truncated to ADDR_WIDTH and mem_req=1.
- IDLE: mem_ready ignored; mem_req=0.
- REQ: mem_req=1 and mem_addr stable every cycle until mem_ready=1. On mem_ready:
  - instr_out <= mem_rdata
  - pc_next <= pc_q + 4 (mod 2^WORD_LENGTH)
  - mem_req <= 0
  - go to DONE
- DONE (exactly one cycle): instr_valid=1, pc_write=1, then IDLE. fetch_start sampled in DONE is ignored; it must be re-asserted in IDLE.
- FAULT: fault=1, mem_req=0, fetch_start ignored. fault_clear=1 moves to IDLE with fault=0 next cycle. fault_clear has no effect outside FAULT.
- Latency: fetch_start at edge N; mem_req high from cycle N+1. If mem_ready is seen at edge N+k (k>=1), instr_valid and pc_write are high during cycle N+k+1. Minimum fetch-to-valid latency is 2 cycles.
- instr_out and pc_next hold their last loaded values until the next successful fetch; faults do not modify them.
- pc_write and instr_valid are never high outside DONE.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined: a counter cleared on entry to REQ increments each REQ cycle without mem_ready. When the count reaches TIMEOUT_CYCLES, go to FAULT, drop mem_req, and raise fault. mem_ready in the same cycle as the timeout wins, giving a normal completion.
- Undefined: REQ waits indefinitely; TIMEOUT_CYCLES is unused; no counter logic is synthesized.

Test Plan:
- Reset then idle: assert reset -> all outputs 0, state IDLE; release, no fetch_start for 10 cycles -> mem_req stays 0.
- Zero-wait fetch: pc_in=32'h0040_0000, pulse fetch_start; mem_ready=1 and mem_rdata=32'h2008_0005 on the first req cycle -> mem_addr=0; next cycle instr_valid=pc_write=1 with instr_out=32'h2008_0005 and pc_next=32'h0040_0004.
- Wait states: pc_in=32'h0040_03FC, mem_ready delayed 3 cycles -> mem_addr=8'hFF held with mem_req=1 for 3 cycles; one pulse of pc_write; pc_next=32'h0040_0400.
- Faults: pc_in=32'h0040_0002 -> fault=1, no mem_req. pc_in=32'h0040_0400 -> fault. pc_in=32'h003F_FFFC -> fault. fault_clear -> fault=0, IDLE.
- Async reset mid-REQ: assert reset while mem_req=1 -> mem_req=0 before the next clock edge; instr_out stays 0; no pc_write pulse.
- FETCH_TIMEOUT_EN: TIMEOUT_CYCLES=16, mem_ready never asserted -> fault=1 after 16 REQ cycles. Repeat with mem_ready on cycle 16 -> normal completion, no fault.
